// File: rtl/usc_rv_pkg.sv
// rtl/usc_rv_pkg.sv - shared decode types, op-ctl layout and opcode constants
package usc_rv_pkg;

    typedef enum logic [3:0] {
        FU_LS  = 4'b0001,
        FU_ALU = 4'b0010,
        FU_MC  = 4'b0100,
        FU_SYS = 4'b1000
    } fu_e;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_FLT_HOLD = 1'b1
    } state_e;

    typedef struct packed {
        logic       src0_v;
        logic [4:0] src0_tag;
        logic       src1_v;
        logic [4:0] src1_tag;
        logic       dst_v;
        logic [4:0] dst_tag;
        fu_e        fu;
        logic [3:0] fu_op;
        logic [31:0] imm;
    } op_ctl_t;

    localparam int USC_RV_OP_CTL_W      = $bits(op_ctl_t);
    localparam int USC_RV_IMM_LSB       = 0;
    localparam int USC_RV_FU_OP_LSB     = 32;
    localparam int USC_RV_FU_LSB        = 36;
    localparam int USC_RV_DST_TAG_LSB   = 40;
    localparam int USC_RV_DST_V_BIT     = 45;
    localparam int USC_RV_SRC1_TAG_LSB  = 46;
    localparam int USC_RV_SRC1_V_BIT    = 51;
    localparam int USC_RV_SRC0_TAG_LSB  = 52;
    localparam int USC_RV_SRC0_V_BIT    = 57;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/usc_rv_dec_pla.sv
// rtl/usc_rv_dec_pla.sv - single-lane combinational opcode decoder
module usc_rv_dec_pla
    import usc_rv_pkg::*;
(
    input  logic [31:0] opc_i,
    input  logic        fault_i,
    output op_ctl_t     ctl_o,
    output logic        illegal_o
);

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        wr;

    assign opcode = opc_i[6:0];
    assign f3     = opc_i[14:12];
    assign f7     = opc_i[31:25];
    assign imm_i  = {{20{opc_i[31]}}, opc_i[31:20]};
    assign imm_s  = {{20{opc_i[31]}}, opc_i[31:25], opc_i[11:7]};
    assign imm_b  = {{19{opc_i[31]}}, opc_i[31], opc_i[7], opc_i[30:25], opc_i[11:8], 1'b0};
    assign imm_u  = {opc_i[31:12], 12'h000};
    assign imm_j  = {{11{opc_i[31]}}, opc_i[31], opc_i[19:12], opc_i[20], opc_i[30:21], 1'b0};

    always_comb begin
        ctl_o          = '0;
        illegal_o      = 1'b0;
        wr             = 1'b0;
        ctl_o.src0_tag = opc_i[19:15];
        ctl_o.src1_tag = opc_i[24:20];
        ctl_o.dst_tag  = opc_i[11:7];
        ctl_o.fu_op    = {opc_i[30], f3};
        case (opcode)
            OPC_LOAD:   begin ctl_o.fu = FU_LS;  ctl_o.src0_v = 1'b1; wr = 1'b1; ctl_o.imm = imm_i; ctl_o.fu_op = {1'b0, f3}; end
            OPC_STORE:  begin ctl_o.fu = FU_LS;  ctl_o.src0_v = 1'b1; ctl_o.src1_v = 1'b1; ctl_o.imm = imm_s; ctl_o.fu_op = {1'b1, f3}; end
            OPC_OPIMM:  begin ctl_o.fu = FU_ALU; ctl_o.src0_v = 1'b1; wr = 1'b1; ctl_o.imm = imm_i; ctl_o.fu_op = {opc_i[30] & (f3 == 3'b101), f3}; end
            OPC_OP: begin
                ctl_o.src0_v = 1'b1;
                ctl_o.src1_v = 1'b1;
                wr           = 1'b1;
                if (f7 == 7'h00 || f7 == 7'h20) ctl_o.fu = FU_ALU;
                else if (f7 == 7'h01)           begin ctl_o.fu = FU_MC; ctl_o.fu_op = {1'b0, f3}; end
                else                            illegal_o = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin ctl_o.fu = FU_ALU; wr = 1'b1; ctl_o.imm = imm_u; end
            OPC_BRANCH: begin ctl_o.fu = FU_ALU; ctl_o.src0_v = 1'b1; ctl_o.src1_v = 1'b1; ctl_o.imm = imm_b; end
            OPC_JAL:    begin ctl_o.fu = FU_ALU; wr = 1'b1; ctl_o.imm = imm_j; end
            OPC_JALR:   begin ctl_o.fu = FU_ALU; ctl_o.src0_v = 1'b1; wr = 1'b1; ctl_o.imm = imm_i; end
            OPC_FENCE:  ctl_o.fu = FU_SYS;
            OPC_SYSTEM: begin ctl_o.fu = FU_SYS; ctl_o.src0_v = 1'b1; wr = 1'b1; ctl_o.imm = imm_i; end
            default:    illegal_o = 1'b1;
        endcase
        ctl_o.dst_v = wr && (opc_i[11:7] != 5'd0);
        // Faulting lanes carry no operands; they are routed to SYS to raise the trap.
        if (fault_i || illegal_o) begin
            ctl_o    = '0;
            ctl_o.fu = FU_SYS;
        end
    end

endmodule

// File: rtl/usc_rv_dec_mlane.sv
// rtl/usc_rv_dec_mlane.sv - multi-lane decode stage with optional skid and fault hold
module usc_rv_dec_mlane
    import usc_rv_pkg::*;
#(
    parameter int LANES   = 2,
    parameter int SKID_EN = 1
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [LANES-1:0]                   ib_vld_i,
    input  logic [LANES-1:0]                   ib_access_flt_i,
    input  logic [LANES-1:0]                   ib_page_flt_i,
    input  logic [LANES*32-1:0]                ib_opc_i,
    output logic                               ib_rdy_o,
    output logic [LANES-1:0]                   dec_vld_o,
    output logic [LANES*USC_RV_OP_CTL_W-1:0]   dec_op_ctl_o,
    output logic [LANES-1:0]                   dec_exc_o,
    input  logic                               dec_rdy_i,
    input  logic                               flush_i
);

    op_ctl_t          new_ctl  [LANES];
    op_ctl_t          out_ctl  [LANES];
    op_ctl_t          skid_ctl [LANES];
    logic [LANES-1:0] new_ill, lane_exc, new_vld, new_exc;
    logic [LANES-1:0] out_vld, out_exc, skid_vld, skid_exc;
    state_e           state;
    logic             out_adv, skid_v, accept, grp_exc, live;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        usc_rv_dec_pla u_pla (
            .opc_i     (ib_opc_i[32*g +: 32]),
            .fault_i   (ib_page_flt_i[g] | ib_access_flt_i[g]),
            .ctl_o     (new_ctl[g]),
            .illegal_o (new_ill[g])
        );
        assign lane_exc[g] = ib_page_flt_i[g] | ib_access_flt_i[g] | new_ill[g];
        assign dec_op_ctl_o[g*USC_RV_OP_CTL_W +: USC_RV_OP_CTL_W] = out_ctl[g];
    end

    // Thermometer mask on ib_vld_i, and nothing younger than the first exception survives.
    always_comb begin
        live    = 1'b1;
        new_vld = '0;
        new_exc = '0;
        for (int i = 0; i < LANES; i++) begin
            live       = live & ib_vld_i[i];
            new_vld[i] = live;
            new_exc[i] = live & lane_exc[i];
            live       = live & ~lane_exc[i];
        end
    end

    assign grp_exc   = |new_exc;
    assign skid_v    = (SKID_EN != 0) && (|skid_vld);
    assign out_adv   = ~(|out_vld) | dec_rdy_i;
    assign ib_rdy_o  = (state == ST_RUN) && !flush_i && ((SKID_EN != 0) ? !skid_v : out_adv);
    assign accept    = (|ib_vld_i) & ib_rdy_o;
    assign dec_vld_o = out_vld;
    assign dec_exc_o = out_exc;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= ST_RUN;
            out_vld  <= '0;
            out_exc  <= '0;
            skid_vld <= '0;
            skid_exc <= '0;
        end else if (flush_i) begin
            state    <= ST_RUN;
            out_vld  <= '0;
            out_exc  <= '0;
            skid_vld <= '0;
            skid_exc <= '0;
        end else begin
            if (out_adv) begin
                if (skid_v) begin
                    out_vld  <= skid_vld;
                    out_exc  <= skid_exc;
                    skid_vld <= '0;
                    skid_exc <= '0;
                end else if (accept) begin
                    out_vld <= new_vld;
                    out_exc <= new_exc;
                end else begin
                    out_vld <= '0;
                    out_exc <= '0;
                end
            end else if (accept) begin
                skid_vld <= new_vld;
                skid_exc <= new_exc;
            end
            if (accept && grp_exc) state <= ST_FLT_HOLD;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < LANES; i++) begin
            if (out_adv)             out_ctl[i]  <= skid_v ? skid_ctl[i] : new_ctl[i];
            if (!out_adv && accept)  skid_ctl[i] <= new_ctl[i];
        end
    end

endmodule

// File: tb/tb_usc_rv_dec_mlane.sv
// tb/tb_usc_rv_dec_mlane.sv - scoreboard bench for usc_rv_dec_mlane
module tb_usc_rv_dec_mlane;
    import usc_rv_pkg::*;

    localparam int L = 2;
    localparam int W = USC_RV_OP_CTL_W;

    typedef struct packed {
        logic [1:0] vld;
        logic [1:0] exc;
        logic [7:0] fu;
        logic [1:0] dv;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_ni;
    logic [L-1:0]    ib_vld_i, ib_access_flt_i, ib_page_flt_i;
    logic [L*32-1:0] ib_opc_i;
    logic            ib_rdy_o;
    logic [L-1:0]    dec_vld_o, dec_exc_o;
    logic [L*W-1:0]  dec_op_ctl_o;
    logic            dec_rdy_i, flush_i;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    bit   hold_m = 1'b0;

    always #5 clk = ~clk;

    usc_rv_dec_mlane #(.LANES(L), .SKID_EN(1)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .ib_vld_i        (ib_vld_i),
        .ib_access_flt_i (ib_access_flt_i),
        .ib_page_flt_i   (ib_page_flt_i),
        .ib_opc_i        (ib_opc_i),
        .ib_rdy_o        (ib_rdy_o),
        .dec_vld_o       (dec_vld_o),
        .dec_op_ctl_o    (dec_op_ctl_o),
        .dec_exc_o       (dec_exc_o),
        .dec_rdy_i       (dec_rdy_i),
        .flush_i         (flush_i)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Functional-unit class of an RV32 opcode; 0 means no legal class.
    function automatic logic [3:0] ref_fu(input logic [31:0] o);
        case (o[6:0])
            7'h03, 7'h23:                             return 4'b0001;
            7'h13, 7'h37, 7'h17, 7'h63, 7'h6f, 7'h67: return 4'b0010;
            7'h33: begin
                if (o[31:25] == 7'h00 || o[31:25] == 7'h20) return 4'b0010;
                if (o[31:25] == 7'h01) return 4'b0100;
                return 4'b0000;
            end
            7'h0f, 7'h73:                             return 4'b1000;
            default:                                  return 4'b0000;
        endcase
    endfunction

    function automatic logic ref_wr(input logic [31:0] o);
        logic w;
        w = (o[6:0] inside {7'h03, 7'h13, 7'h33, 7'h37, 7'h17, 7'h6f, 7'h67, 7'h73});
        return w && (o[11:7] != 5'd0);
    endfunction

    function automatic exp_t model(input logic [1:0] v, input logic [63:0] opc,
                                   input logic [1:0] pf, input logic [1:0] af);
        exp_t        e;
        logic [31:0] o;
        logic [3:0]  fu;
        e = '0;
        for (int i = 0; i < L; i++) begin
            if (!v[i]) break;
            o  = opc[32*i +: 32];
            fu = ref_fu(o);
            e.vld[i] = 1'b1;
            if (pf[i] || af[i] || fu == 4'b0000) begin
                e.exc[i]      = 1'b1;
                e.fu[4*i +: 4] = 4'b1000;
                break;
            end
            e.fu[4*i +: 4] = fu;
            e.dv[i]        = ref_wr(o);
        end
        return e;
    endfunction

    function automatic logic [31:0] rnd_opc();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 13))
            0:  r[6:0] = 7'h03;
            1:  r[6:0] = 7'h23;
            2:  r[6:0] = 7'h13;
            3:  begin r[6:0] = 7'h33; r[31:25] = 7'h00; end
            4:  begin r[6:0] = 7'h33; r[31:25] = 7'h20; end
            5:  begin r[6:0] = 7'h33; r[31:25] = 7'h01; end
            6:  r[6:0] = 7'h37;
            7:  r[6:0] = 7'h17;
            8:  r[6:0] = 7'h63;
            9:  r[6:0] = 7'h6f;
            10: r[6:0] = 7'h67;
            11: r[6:0] = ($urandom_range(0, 1) != 0) ? 7'h73 : 7'h0f;
            12: r[6:0] = 7'h33;
            default: ;
        endcase
        return r;
    endfunction

    // Drives one cycle of stimulus; called at posedge+1, returns at the next posedge+1.
    task automatic drive(input logic [1:0] v, input logic [31:0] o0, input logic [31:0] o1,
                         input logic [1:0] pf, input logic [1:0] af, input logic rdy, input logic fl);
        logic exp_rdy;
        exp_t e;
        ib_vld_i        = v;
        ib_opc_i        = {o1, o0};
        ib_page_flt_i   = pf;
        ib_access_flt_i = af;
        dec_rdy_i       = rdy;
        flush_i         = fl;
        exp_rdy = !hold_m && !fl && (sb.size() < 2);
        @(negedge clk);
        chk("ib_rdy", 128'(ib_rdy_o), 128'(exp_rdy));
        if (exp_rdy && (|v)) begin
            e = model(v, {o1, o0}, pf, af);
            if (e.vld != 2'b00) sb.push_back(e);
            if (e.exc != 2'b00) hold_m = 1'b1;
        end
        if (fl) begin
            #1;
            sb.delete();
            hold_m = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares each handshaken output group and checks stall stability.
    initial begin
        logic         pv, pfl;
        logic [127:0] prev;
        exp_t         e;
        pv = 1'b0; pfl = 1'b0; prev = '0;
        forever begin
            @(negedge clk);
            if (!rst_ni) begin
                pv = 1'b0;
                continue;
            end
            if (pv && !pfl)
                chk("stall_stable", {8'h0, dec_vld_o, dec_exc_o, dec_op_ctl_o}, prev);
            pv   = (|dec_vld_o) && !dec_rdy_i;
            pfl  = flush_i;
            prev = {8'h0, dec_vld_o, dec_exc_o, dec_op_ctl_o};
            if ((|dec_vld_o) && dec_rdy_i) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", 128'(dec_vld_o), 128'(0));
                end else begin
                    e = sb.pop_front();
                    chk("dec_vld", 128'(dec_vld_o), 128'(e.vld));
                    chk("dec_exc", 128'(dec_exc_o), 128'(e.exc));
                    for (int i = 0; i < L; i++) begin
                        if (e.vld[i]) begin
                            chk($sformatf("fu_l%0d", i), 128'(dec_op_ctl_o[i*W + USC_RV_FU_LSB +: 4]),
                                128'(e.fu[4*i +: 4]));
                            chk($sformatf("dst_v_l%0d", i), 128'(dec_op_ctl_o[i*W + USC_RV_DST_V_BIT]),
                                128'(e.dv[i]));
                        end
                    end
                end
            end
        end
    end

    initial begin
        rst_ni = 1'b0; ib_vld_i = '0; ib_opc_i = '0; ib_page_flt_i = '0; ib_access_flt_i = '0;
        dec_rdy_i = 1'b1; flush_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_vld", 128'(dec_vld_o), 128'(0));
        chk("rst_exc", 128'(dec_exc_o), 128'(0));
        @(posedge clk); #1;
        rst_ni = 1'b1;

        drive(2'b11, 32'h00000013, 32'h00002003, 2'b00, 2'b00, 1'b1, 1'b0);
        drive(2'b00, 32'h0, 32'h0, 2'b00, 2'b00, 1'b1, 1'b0);
        drive(2'b01, 32'h00500093, 32'hFFFFFFFF, 2'b00, 2'b00, 1'b1, 1'b0);
        drive(2'b00, 32'h0, 32'h0, 2'b00, 2'b00, 1'b1, 1'b0);

        drive(2'b11, 32'h00208133, 32'h00312023, 2'b00, 2'b00, 1'b0, 1'b0);
        drive(2'b11, 32'h02310233, 32'h000280e7, 2'b00, 2'b00, 1'b0, 1'b0);
        drive(2'b11, 32'h00100093, 32'h00100093, 2'b00, 2'b00, 1'b0, 1'b0);
        drive(2'b00, 32'h0, 32'h0, 2'b00, 2'b00, 1'b0, 1'b0);
        repeat (3) drive(2'b00, 32'h0, 32'h0, 2'b00, 2'b00, 1'b1, 1'b0);

        drive(2'b11, 32'h00000013, 32'h02000033, 2'b01, 2'b00, 1'b1, 1'b0);
        repeat (3) drive(2'b11, 32'h00000013, 32'h00000013, 2'b00, 2'b00, 1'b1, 1'b0);
        drive(2'b00, 32'h0, 32'h0, 2'b00, 2'b00, 1'b1, 1'b1);
        drive(2'b00, 32'h0, 32'h0, 2'b00, 2'b00, 1'b1, 1'b0);

        drive(2'b11, 32'h00000073, 32'hFFFFFFFF, 2'b00, 2'b00, 1'b1, 1'b0);
        drive(2'b11, 32'h00000013, 32'h00000013, 2'b00, 2'b00, 1'b1, 1'b0);
        drive(2'b00, 32'h0, 32'h0, 2'b00, 2'b00, 1'b1, 1'b1);

        drive(2'b11, 32'h00000013, 32'h00000013, 2'b00, 2'b00, 1'b0, 1'b0);
        drive(2'b11, 32'h00000013, 32'h00000013, 2'b00, 2'b00, 1'b0, 1'b1);
        ib_vld_i = '0; flush_i = 1'b0;
        @(negedge clk);
        chk("flush_clr_vld", 128'(dec_vld_o), 128'(0));
        chk("flush_run_rdy", 128'(ib_rdy_o), 128'(1));
        @(posedge clk); #1;

        drive(2'b11, 32'h00208133, 32'h00312023, 2'b00, 2'b00, 1'b0, 1'b0);
        drive(2'b11, 32'h02310233, 32'h000280e7, 2'b00, 2'b00, 1'b0, 1'b0);
        rst_ni = 1'b0;
        sb.delete();
        hold_m = 1'b0;
        @(negedge clk);
        chk("rst_stall_vld", 128'(dec_vld_o), 128'(0));
        chk("rst_stall_exc", 128'(dec_exc_o), 128'(0));
        @(posedge clk); #1;
        rst_ni = 1'b1;

        for (int n = 0; n < 600; n++) begin
            logic [1:0] v, pf, af;
            v  = 2'($urandom_range(0, 3));
            pf = {($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0)};
            af = {($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0)};
            if (hold_m)
                drive(v, rnd_opc(), rnd_opc(), pf, af, 1'b1,
                      (sb.size() == 0) && ($urandom_range(0, 1) != 0));
            else
                drive(v, rnd_opc(), rnd_opc(), pf, af, ($urandom_range(0, 3) != 0),
                      ($urandom_range(0, 40) == 0));
        end

        repeat (6) drive(2'b00, 32'h0, 32'h0, 2'b00, 2'b00, 1'b1, 1'b0);
        chk("drain_empty", 128'(sb.size()), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
